// File: rtl/cc_viterbi_dec_if.sv
// -----------------------------------------------------------------------------
// cc_viterbi_dec_if
// Stream bundle between the depuncture stage, the Viterbi decoder and the
// RS decoder.
//   in_z[1:0]  received {Y,X} pair            (upstream -> decoder)
//   in_valid   in_z valid this cycle          (upstream -> decoder)
//   in_last    final pair of the block        (upstream -> decoder)
//   in_ready   decoder accepts in_z           (decoder  -> upstream)
//   out_bit    decoded bit                    (decoder  -> downstream)
//   out_valid  out_bit strobe, no backpressure (decoder -> downstream)
//   out_last   final decoded bit of the block (decoder  -> downstream)
// The master modport is the side that feeds pairs and consumes decoded bits;
// the slave modport is the decoder.
// -----------------------------------------------------------------------------
interface cc_viterbi_dec_if;
  logic [1:0] in_z;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_last;

  modport master (
    output in_z, in_valid, in_last,
    input  in_ready, out_bit, out_valid, out_last
  );

  modport slave (
    input  in_z, in_valid, in_last,
    output in_ready, out_bit, out_valid, out_last
  );
endinterface

// File: rtl/cc_viterbi_dec.sv
// -----------------------------------------------------------------------------
// cc_viterbi_dec
// Hard-decision Viterbi decoder for the rate-1/2, K=7 convolutional code
// (G1=171 octal -> X, G2=133 octal -> Y), 64 states, register-exchange
// survivor memory, zero-start state and zero-tail block termination.
//
// Parameters:
//   TB_DEPTH  survivor length / decision delay in bits (8..64)
//   PM_W      path-metric width in bits (>= 6)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state
//   bus    cc_viterbi_dec_if.slave: in_z/in_valid/in_last/in_ready input
//          stream and out_bit/out_valid/out_last output stream
//
// Flow: INIT (one cycle, metrics loaded) -> RUN (one ACS per accepted pair,
// decisions emitted TB_DEPTH steps late) -> FLUSH (remaining bits read out of
// the state-0 survivor, oldest first) -> INIT.
// -----------------------------------------------------------------------------
module cc_viterbi_dec #(
  parameter int TB_DEPTH = 32,
  parameter int PM_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  cc_viterbi_dec_if.slave   bus
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int CW = $clog2(TB_DEPTH + 1);
  localparam int IW = $clog2(TB_DEPTH);

  // Non-zero start states are handicapped so the zero-start path wins early.
  localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

  logic [1:0]          state_reg;
  logic [PM_W-1:0]     pm_reg   [0:63];
  logic [TB_DEPTH-1:0] surv_reg [0:63];
  logic [CW-1:0]       cnt_reg;    // accepted steps, saturating at TB_DEPTH
  logic [IW-1:0]       idx_reg;    // survivor bit currently shown in FLUSH
  logic                run_valid_reg;
  logic                run_bit_reg;

  logic [PM_W-1:0]     pm_acs   [0:63];
  logic [PM_W-1:0]     pm_new   [0:63];
  logic [TB_DEPTH-1:0] surv_new [0:63];
  logic [63:0]         msb_vec;
  logic                norm;
  logic                accept;
  logic [5:0]          best_idx;
  logic [PM_W-1:0]     best_pm;
  logic                best_bit;

  assign accept = bus.in_valid && (state_reg == ST_RUN);
  assign norm   = &msb_vec;

  // ---------------------------------------------------------------------------
  // Add-compare-select, one butterfly half per destination state.
  // Destination s' is reached from {x, s'[5:1]} with input bit s'[0], so the
  // history seen by the encoder is d1..d5 = s'[1..5] and d6 = x.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_acs
      localparam logic [5:0] S  = 6'(gi);
      localparam logic [5:0] P0 = {1'b0, S[5:1]};
      localparam logic [5:0] P1 = {1'b1, S[5:1]};
      localparam logic       X0 = S[0] ^ S[1] ^ S[2] ^ S[3];
      localparam logic       Y0 = S[0] ^ S[2] ^ S[3] ^ S[5];
      // d6 feeds both generators, so the x=1 branch is the complement.
      localparam logic [1:0] E0 = {Y0, X0};
      localparam logic [1:0] E1 = {~Y0, ~X0};

      logic [1:0]          d0, d1;
      logic [1:0]          bm0, bm1;
      logic [PM_W-1:0]     c0, c1;
      logic                sel;
      logic [TB_DEPTH-1:0] surv_sel;

      assign d0  = bus.in_z ^ E0;
      assign d1  = bus.in_z ^ E1;
      assign bm0 = {d0[1] & d0[0], d0[1] ^ d0[0]};
      assign bm1 = {d1[1] & d1[0], d1[1] ^ d1[0]};
      assign c0  = pm_reg[P0] + {{(PM_W-2){1'b0}}, bm0};
      assign c1  = pm_reg[P1] + {{(PM_W-2){1'b0}}, bm1};
      // Strict compare: a tie keeps the x=0 predecessor.
      assign sel = (c1 < c0);

      assign pm_acs[gi]   = sel ? c1 : c0;
      assign surv_sel     = sel ? surv_reg[P1] : surv_reg[P0];
      assign surv_new[gi] = {surv_sel[TB_DEPTH-2:0], S[0]};
      assign msb_vec[gi]  = pm_acs[gi][PM_W-1];
      // Metric spread stays far below 2^(PM_W-2), so once every MSB is set
      // dropping it is a uniform subtraction that preserves all comparisons.
      assign pm_new[gi]   = {pm_acs[gi][PM_W-1] & ~norm, pm_acs[gi][PM_W-2:0]};
    end
  endgenerate

  // Best state after this step's ACS; strict '<' keeps the lowest index on ties.
  always_comb begin
    best_idx = 6'd0;
    best_pm  = pm_new[0];
    for (int i = 1; i < 64; i++) begin
      if (pm_new[i] < best_pm) begin
        best_pm  = pm_new[i];
        best_idx = 6'(i);
      end
    end
    best_bit = surv_new[best_idx][TB_DEPTH-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      run_valid_reg <= 1'b0;
      run_bit_reg   <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        pm_reg[i]   <= (i == 0) ? '0 : PM_INIT;
        surv_reg[i] <= '0;
      end
    end else begin
      run_valid_reg <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          for (int i = 0; i < 64; i++) begin
            pm_reg[i]   <= (i == 0) ? '0 : PM_INIT;
            surv_reg[i] <= '0;
          end
          cnt_reg   <= '0;
          state_reg <= ST_RUN;
        end

        ST_RUN: begin
          if (accept) begin
            for (int i = 0; i < 64; i++) begin
              pm_reg[i]   <= pm_new[i];
              surv_reg[i] <= surv_new[i];
            end
            if (bus.in_last) begin
              // pending = min(N, TB_DEPTH); idx starts at pending-1.
              idx_reg   <= (cnt_reg >= CW'(TB_DEPTH - 1)) ? IW'(TB_DEPTH - 1)
                                                          : IW'(cnt_reg);
              state_reg <= ST_FLUSH;
            end else begin
              if (cnt_reg >= CW'(TB_DEPTH - 1)) begin
                run_valid_reg <= 1'b1;
                run_bit_reg   <= best_bit;
              end
              if (cnt_reg != CW'(TB_DEPTH)) begin
                cnt_reg <= cnt_reg + CW'(1);
              end
            end
          end
        end

        ST_FLUSH: begin
          if (idx_reg == '0) begin
            state_reg <= ST_INIT;
          end else begin
            idx_reg <= idx_reg - IW'(1);
          end
        end

        default: state_reg <= ST_INIT;
      endcase
    end
  end

  // FLUSH output is decoded straight from state, so an asynchronous reset
  // removes it in the same instant as the RUN strobe.
  assign bus.in_ready  = (state_reg == ST_RUN);
  assign bus.out_valid = run_valid_reg || (state_reg == ST_FLUSH);
  assign bus.out_bit   = (state_reg == ST_FLUSH) ? surv_reg[0][idx_reg] : run_bit_reg;
  assign bus.out_last  = (state_reg == ST_FLUSH) && (idx_reg == '0);

endmodule

// File: tb/tb_cc_viterbi_dec.sv
// -----------------------------------------------------------------------------
// tb_cc_viterbi_dec
// Directed bench for cc_viterbi_dec (TB_DEPTH=32, PM_W=8): reset state, zero
// block, impulse with latency, error correction, short block, long block with
// heavy metric growth against an unbounded-metric traceback model, and reset
// during FLUSH.
// -----------------------------------------------------------------------------
module tb_cc_viterbi_dec;
  localparam int TB_DEPTH = 32;
  localparam int PM_W     = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cc_viterbi_dec_if bus_if ();

  cc_viterbi_dec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       out_bits  [$];
  logic       out_lasts [$];
  logic       out_rdy   [$];
  int         out_cyc   [$];
  int         acc_cyc   [$];
  logic       data_q    [$];
  logic [1:0] stim      [$];
  logic       exp_q     [$];

  int         mpm  [0:63];
  int         npm  [0:63];
  logic [63:0] mdec [0:1023];

  // Output / accept monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus_if.out_valid === 1'b1) begin
      out_bits.push_back(bus_if.out_bit);
      out_lasts.push_back(bus_if.out_last);
      out_rdy.push_back(bus_if.in_ready);
      out_cyc.push_back(cyc);
    end
    if (bus_if.in_valid === 1'b1 && bus_if.in_ready === 1'b1)
      acc_cyc.push_back(cyc);
  end

  // Code symbol {Y,X} from the generator polynomials; tap vector {b,d1..d6}.
  function automatic logic [1:0] code_sym(input logic b, input logic [5:0] h);
    logic [6:0] r;
    r = {b, h[0], h[1], h[2], h[3], h[4], h[5]};
    return {^(r & 7'o133), ^(r & 7'o171)};
  endfunction

  function automatic void clear_log();
    out_bits.delete(); out_lasts.delete(); out_rdy.delete();
    out_cyc.delete(); acc_cyc.delete();
  endfunction

  function automatic void encode_data();
    logic [5:0] h;
    h = '0;
    stim.delete();
    foreach (data_q[i]) begin
      stim.push_back(code_sym(data_q[i], h));
      h = {h[4:0], data_q[i]};
    end
  endfunction

  task automatic send_pair(input logic [1:0] z, input logic last);
    int n;
    bus_if.in_z     = z;
    bus_if.in_valid = 1'b1;
    bus_if.in_last  = last;
    n = 0;
    @(negedge clk);
    while (bus_if.in_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (bus_if.in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready=%b required 1", bus_if.in_ready);
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
  endtask

  task automatic play_block();
    @(posedge clk); #1;
    foreach (stim[i]) send_pair(stim[i], i == stim.size() - 1);
  endtask

  task automatic wait_outputs(input int count, input int budget, output bit ok);
    int n;
    n = 0;
    while (out_bits.size() < count && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    ok = (out_bits.size() >= count);
  endtask

  function automatic logic trace_bit(input int k, input logic [5:0] s0, input int j);
    logic [5:0] s;
    s = s0;
    for (int t = k; t > j; t--) s = {mdec[t][s], s[5:1]};
    return s[0];
  endfunction

  // Unbounded-integer metrics with explicit decisions and traceback.
  function automatic void run_model();
    int n, pend, bm0, bm1, c0, c1, best_m;
    logic [5:0] s, p0, p1, best;
    n = stim.size();
    exp_q.delete();
    mpm[0] = 0;
    for (int i = 1; i < 64; i++) mpm[i] = 1 << (PM_W - 2);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 64; i++) begin
        s   = 6'(i);
        p0  = {1'b0, s[5:1]};
        p1  = {1'b1, s[5:1]};
        bm0 = $countones(stim[k] ^ code_sym(s[0], p0));
        bm1 = $countones(stim[k] ^ code_sym(s[0], p1));
        c0  = mpm[p0] + bm0;
        c1  = mpm[p1] + bm1;
        if (c1 < c0) begin npm[i] = c1; mdec[k][i] = 1'b1; end
        else         begin npm[i] = c0; mdec[k][i] = 1'b0; end
      end
      for (int i = 0; i < 64; i++) mpm[i] = npm[i];
      if (k != n - 1 && k >= TB_DEPTH - 1) begin
        best = 6'd0; best_m = mpm[0];
        for (int i = 1; i < 64; i++)
          if (mpm[i] < best_m) begin best_m = mpm[i]; best = 6'(i); end
        exp_q.push_back(trace_bit(k, best, k - TB_DEPTH + 1));
      end
    end
    pend = (n < TB_DEPTH) ? n : TB_DEPTH;
    for (int j = n - pend; j < n; j++) exp_q.push_back(trace_bit(n - 1, 6'd0, j));
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus_if.in_ready); end
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); end
    total++; if (bus_if.out_bit !== 1'b0) begin bad++; $display("FAIL reset_out_bit: got %b want 0", bus_if.out_bit); end
    total++; if (bus_if.out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last: got %b want 0", bus_if.out_last); end
    reset = 1'b0;
    #1;
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL init_in_ready: got %b want 0", bus_if.in_ready); end
    @(posedge clk); #1;
    total++; if (bus_if.in_ready !== 1'b1) begin bad++; $display("FAIL run_in_ready: got %b want 1", bus_if.in_ready); end
    $display("reset: in_ready=%b out_valid=%b", bus_if.in_ready, bus_if.out_valid);
  endtask

  task automatic test_zero_block();
    bit ok;
    int run_n, flush_n;
    clear_log();
    data_q.delete();
    repeat (40) data_q.push_back(1'b0);
    encode_data();
    play_block();
    wait_outputs(40, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL zero_count: got %0d bits want 40", out_bits.size()); return; end
    repeat (5) @(negedge clk);
    #1;
    total++; if (out_bits.size() != 40) begin bad++; $display("FAIL zero_extra: got %0d bits want 40", out_bits.size()); end
    run_n = 0; flush_n = 0;
    for (int i = 0; i < 40; i++) begin
      total++; if (out_bits[i] !== 1'b0) begin bad++; $display("FAIL zero_bit%0d: got %b want 0", i, out_bits[i]); end
      total++; if (out_lasts[i] !== (i == 39)) begin bad++; $display("FAIL zero_last%0d: got %b want %b", i, out_lasts[i], i == 39); end
      if (out_rdy[i] === 1'b1) run_n++; else flush_n++;
    end
    total++; if (run_n != 8) begin bad++; $display("FAIL zero_run_count: got %0d want 8", run_n); end
    total++; if (flush_n != 32) begin bad++; $display("FAIL zero_flush_count: got %0d want 32", flush_n); end
    $display("zero block: %0d bits, run=%0d flush=%0d", out_bits.size(), run_n, flush_n);
  endtask

  task automatic test_impulse(input bit with_errors);
    bit ok;
    clear_log();
    data_q.delete();
    data_q.push_back(1'b1);
    repeat (39) data_q.push_back(1'b0);
    encode_data();
    if (with_errors) begin
      stim[3]  = 2'b10;
      stim[20] = 2'b01;
    end
    play_block();
    wait_outputs(40, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL impulse_count: got %0d bits want 40", out_bits.size()); return; end
    if (!with_errors) begin
      total++;
      if (out_cyc[0] != acc_cyc[31] + 1) begin
        bad++; $display("FAIL impulse_latency: first out at %0d want %0d", out_cyc[0], acc_cyc[31] + 1);
      end
    end
    for (int i = 0; i < 40; i++) begin
      total++; if (out_bits[i] !== (i == 0)) begin bad++; $display("FAIL impulse_bit%0d (err=%0d): got %b want %b", i, with_errors, out_bits[i], i == 0); end
    end
    total++; if (out_lasts[39] !== 1'b1) begin bad++; $display("FAIL impulse_last: got %b want 1", out_lasts[39]); end
    $display("impulse (errors=%0d): first bit=%b first out cycle=%0d", with_errors, out_bits[0], out_cyc[0]);
  endtask

  task automatic test_short_block();
    bit ok;
    logic [9:0] pattern;
    clear_log();
    pattern = 10'b1011000000;
    data_q.delete();
    for (int i = 9; i >= 0; i--) data_q.push_back(pattern[i]);
    encode_data();
    play_block();
    wait_outputs(10, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL short_count: got %0d bits want 10", out_bits.size()); return; end
    total++; if (out_cyc[0] != acc_cyc[9] + 1) begin bad++; $display("FAIL short_first: at %0d want %0d", out_cyc[0], acc_cyc[9] + 1); end
    for (int i = 0; i < 10; i++) begin
      total++; if (out_bits[i] !== pattern[9-i]) begin bad++; $display("FAIL short_bit%0d: got %b want %b", i, out_bits[i], pattern[9-i]); end
      total++; if (out_lasts[i] !== (i == 9)) begin bad++; $display("FAIL short_last%0d: got %b want %b", i, out_lasts[i], i == 9); end
      total++; if (out_rdy[i] !== 1'b0) begin bad++; $display("FAIL short_ready%0d: got %b want 0", i, out_rdy[i]); end
      total++; if (out_cyc[i] != out_cyc[0] + i) begin bad++; $display("FAIL short_cycle%0d: got %0d want %0d", i, out_cyc[i], out_cyc[0] + i); end
    end
    $display("short block: %0d bits over %0d cycles", out_bits.size(), out_cyc[9] - out_cyc[0] + 1);
  endtask

  task automatic test_normalisation();
    bit ok;
    int errs;
    clear_log();
    data_q.delete();
    for (int i = 0; i < 594; i++) data_q.push_back(1'($urandom_range(0, 1)));
    repeat (6) data_q.push_back(1'b0);
    encode_data();
    for (int i = 4; i < 600; i += 5) stim[i] = ~stim[i];
    run_model();
    play_block();
    wait_outputs(600, 1500, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL norm_count: got %0d bits want 600", out_bits.size()); return; end
    errs = 0;
    for (int i = 0; i < 600; i++) begin
      total++;
      if (out_bits[i] !== exp_q[i]) begin
        bad++; errs++;
        if (errs <= 10) $display("FAIL norm_bit%0d: got %b want %b", i, out_bits[i], exp_q[i]);
      end
    end
    total++; if (out_lasts[599] !== 1'b1) begin bad++; $display("FAIL norm_last: got %b want 1", out_lasts[599]); end
    $display("normalisation block: 600 bits, %0d differing from model", errs);
  endtask

  task automatic test_reset_in_flush();
    bit ok;
    int held;
    clear_log();
    data_q.delete();
    repeat (40) data_q.push_back(1'b0);
    encode_data();
    play_block();
    wait_outputs(11, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rif_reach_flush: got %0d bits want 11", out_bits.size()); return; end
    @(posedge clk); #1;
    total++; if (bus_if.out_valid !== 1'b1) begin bad++; $display("FAIL rif_flushing: out_valid=%b want 1", bus_if.out_valid); end
    reset = 1'b1;
    #1;
    total++; if (bus_if.out_valid !== 1'b0) begin bad++; $display("FAIL rif_out_valid: got %b want 0", bus_if.out_valid); end
    total++; if (bus_if.out_last !== 1'b0) begin bad++; $display("FAIL rif_out_last: got %b want 0", bus_if.out_last); end
    total++; if (bus_if.in_ready !== 1'b0) begin bad++; $display("FAIL rif_in_ready: got %b want 0", bus_if.in_ready); end
    held = out_bits.size();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    total++; if (out_bits.size() != held) begin bad++; $display("FAIL rif_discard: got %0d bits want %0d", out_bits.size(), held); end
    $display("reset in flush: outputs stopped after %0d bits", held);

    clear_log();
    play_block();
    wait_outputs(40, 200, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rif_new_count: got %0d bits want 40", out_bits.size()); return; end
    for (int i = 0; i < 40; i++) begin
      total++; if (out_bits[i] !== 1'b0) begin bad++; $display("FAIL rif_new_bit%0d: got %b want 0", i, out_bits[i]); end
      total++; if (out_lasts[i] !== (i == 39)) begin bad++; $display("FAIL rif_new_last%0d: got %b want %b", i, out_lasts[i], i == 39); end
    end
    $display("post-reset zero block: %0d bits, last=%b", out_bits.size(), out_lasts[39]);
  endtask

  initial begin
    reset           = 1'b1;
    bus_if.in_z     = 2'b00;
    bus_if.in_valid = 1'b0;
    bus_if.in_last  = 1'b0;
    test_reset();
    test_zero_block();
    test_impulse(1'b0);
    test_impulse(1'b1);
    test_short_block();
    test_normalisation();
    test_reset_in_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_viterbi_dec.md
Name: cc_viterbi_dec

Overview:
- Hard-decision Viterbi decoder for the 802.16 rate-1/2, K=7 convolutional code: G1=171 octal (X), G2=133 octal (Y), 64 states.
- Receive-side mirror of the transmit convolutional encoder. Consumes one {Y,X} pair per trellis step and emits decoded bits serially.
- Uses register-exchange survivor memory, zero-start state and zero-tail block termination. Sits between deinterleaver/depuncture and RS decoder.

Parameters:
- TB_DEPTH, 32, survivor length in bits (decision delay); legal range 8..64.
- PM_W, 8, path-metric width in bits; must be at least 6.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_z  input  2  received pair; in_z[0]=X (G1), in_z[1]=Y (G2).
- in_valid  input  1  in_z valid this cycle.
- in_last  input  1  qualifies final pair of block (tail included); sampled with in_valid.
- in_ready  output  1  decoder accepts in_z this cycle.
- out_bit  output  1  decoded bit.
- out_valid  output  1  out_bit valid; single-cycle strobe, no backpressure.
- out_last  output  1  final decoded bit of block; only with out_valid.

Behaviour:
- Reset values: in_ready=0, out_bit=0, out_valid=0, out_last=0, fsm=INIT, step count=0, survivors=0, pm[0]=0, pm[1..63]=2^(PM_W-2).
- Trellis state s[5:0]: s[0] is the newest input bit, s[5] the oldest.
  - Transition p->s' with input b: s'={p[4:0],b}.
  - Predecessors of s': {x,s'[5:1]} for x=0,1.
- Expected symbol for b plus history p (d1=p[0]..d6=p[5]):
  - X = b^d1^d2^d3^d6.
  - Y = b^d2^d3^d5^d6.
- Branch metric: Hamming distance between in_z and {Y,X}, range 0..2.
- ACS, performed once per accepted pair (in_valid & in_ready):
  - new pm[s'] = min over both predecessors of pm[p]+bm.
  - Tie selects the x=0 predecessor.
  - surv[s'] = {surv[p_sel][TB_DEPTH-2:0], s'[0]}.
- Normalisation, same cycle as ACS: if every new pm has its MSB set, clear the MSB of all 64. Metrics must never wrap.
- Best state: minimum pm over the post-ACS metrics; ties go to the lowest index.
- FSM states:
  - INIT: one cycle, loads initial metrics, in_ready=0, then goes to RUN.
  - RUN: in_ready=1.
    - On an accepted non-last step k (0-based) with k >= TB_DEPTH-1: next cycle out_valid=1, out_bit = bit TB_DEPTH-1 of the best state's survivor, i.e. decoded bit k-TB_DEPTH+1. Latency is TB_DEPTH steps plus 1 cycle.
    - On an accepted last step: no RUN emission. Go to FLUSH with pending = min(N, TB_DEPTH), where N = total steps.
  - FLUSH: in_ready=0.
    - Emits pending bits from the state-0 survivor, oldest first, one per cycle, out_valid=1 every cycle.
    - out_last=1 on the final bit, then go to INIT.
- Every block yields exactly N decoded bits, tail included; the downstream stage strips the 6 tail bits.
- Blocks with N < TB_DEPTH emit nothing in RUN and all N bits in FLUSH.
- N=1 (in_last on the first pair): one bit in FLUSH with out_last=1.
- in_last without in_valid: ignored.
- in_valid during INIT/FLUSH: not accepted. The upstream must hold the pair.
- Reset mid-RUN or mid-FLUSH:
  - All outputs drop immediately (asynchronous).
  - Remaining pending bits are discarded; no out_last.
  - Decoding restarts from INIT after reset deasserts.

Test Plan:
- Zero block: 40 pairs of 2'b00, last on the 40th -> 40 zero bits.
  - 8 bits emitted in RUN, 32 in FLUSH, out_last on the 40th bit.
- Impulse: input 1 followed by 39 zeros encodes to {Y,X} = 11,01,11,11,00,10,11, then 00 x33 -> decoded 1 followed by 39 zeros.
  - First out_valid appears 1 cycle after step 31 is accepted.
- Error correction: same impulse stream with in_z of step 3 flipped to 2'b10 and step 20 flipped to 2'b01 -> output identical to the error-free case.
- Short block: N=10 pairs encoding 1011000000 (including tail) -> no RUN output; FLUSH emits 1,0,1,1,0,0,0,0,0,0 on 10 consecutive cycles, out_last on the 10th; in_ready=0 throughout FLUSH.
- Metric normalisation: 600 pairs of random data with every 5th pair fully inverted, PM_W=8 -> output matches the golden model bit-exactly; no pm wrap (assert 0 <= pm-spread < 2^(PM_W-2)).
- Reset in FLUSH: assert reset after the 3rd FLUSH bit -> out_valid=0 immediately; a new 40-pair zero block afterwards decodes correctly with the next out_last on its 40th bit.
